cache_refill_unit: RTL

CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

---
 rtl/cache_refill_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cache_refill_unit.sv
// cache_refill_unit
//   Services one cache miss: optionally writes the dirty victim block back
//   to memory word by word, then fills the missing block from memory into
//   the data array, then pulses blk_end for one cycle.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   start           miss request (sampled in IDLE only)
//   dirty_in        victim is dirty (sampled with start)
//   blk_addr        word address of the missing block (latched on start)
//   victim_addr     word address of the victim block (latched on start)
//   victim_data     data-array read data at arr_idx
//   mem_req/mem_we  memory request valid / write (1) or read (0)
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_ack         memory completes the current request this cycle
//   mem_rdata       memory read data, valid with mem_ack during fill
//   arr_idx         data-array word index (read in write-back, write in fill)
//   arr_we          data-array write enable
//   arr_wdata       data-array write data
//   busy            any state other than IDLE
//   blk_end         one-cycle pulse when the fill is complete
module cache_refill_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dirty_in,
    input  logic [ADDR_W-1:0] blk_addr,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [DATA_W-1:0] victim_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  arr_idx,
    output logic              arr_we,
    output logic [DATA_W-1:0] arr_wdata,
    output logic              busy,
    output logic              blk_end
);

    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Only the block-aligned part of each address is kept: the word offset
    // always comes from cnt, so the low bits of the inputs are don't-care.
    typedef struct packed {
        logic [TAG_W-1:0] blk_tag;
        logic [TAG_W-1:0] vic_tag;
    } miss_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    miss_t            miss_q;
    logic             last_word;

    // Word-offset bits of the request addresses are intentionally dropped.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{blk_addr[IDX_W-1:0], victim_addr[IDX_W-1:0]};

    assign last_word = (cnt_q == {IDX_W{1'b1}});

    // The dirty flag is consumed by the IDLE transition itself: whether a
    // write-back happens is captured in the choice of WB vs FILL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && start) begin
                miss_q.blk_tag <= blk_addr[ADDR_W-1:IDX_W];
                miss_q.vic_tag <= victim_addr[ADDR_W-1:IDX_W];
            end
        end
    end

    // Next state and outputs. All data outputs are forced to zero outside
    // WB/FILL so that reset (which forces IDLE) zeroes every output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        arr_idx   = '0;
        arr_we    = 1'b0;
        arr_wdata = '0;
        busy      = 1'b1;
        blk_end   = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cnt_d   = '0;
                    state_d = dirty_in ? WB : FILL;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                // Concatenation keeps the burst inside the victim block.
                mem_addr  = {miss_q.vic_tag, cnt_q};
                mem_wdata = victim_data;
                arr_idx   = cnt_q;
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;   // wraps to 0 for the fill
                    if (last_word)
                        state_d = FILL;
                end
            end
            FILL: begin
                mem_req   = 1'b1;
                mem_addr  = {miss_q.blk_tag, cnt_q};
                arr_idx   = cnt_q;
                arr_we    = mem_ack;
                arr_wdata = mem_rdata;
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word)
                        state_d = DONE;
                end
            end
            DONE: begin
                blk_end = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
